// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline hazard/forwarding bundle between the datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_re, id_rs2_re;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we;
    logic        ex_redirect, mem_req, mem_ack;
    logic        pc_hold, if_id_hold, if_id_flush;
    logic        flush, load_use, suspend;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_rd, mem_rd, wb_rd,
               ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we, ex_redirect, mem_req, mem_ack,
        input  pc_hold, if_id_hold, if_id_flush, flush, load_use, suspend,
               fwd_a, fwd_b, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_rd, mem_rd, wb_rd,
               ex_rf_we, ex_is_load, mem_rf_we, wb_rf_we, ex_redirect, mem_req, mem_ack,
        output pc_hold, if_id_hold, if_id_flush, flush, load_use, suspend,
               fwd_a, fwd_b, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect flush, operand forwarding and data-memory wait control.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic cpu_clk,
    input logic cpu_rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic        mem_timeout_q;
    logic        post_rst_q;
    logic [31:0] stall_q;
    logic        hazard, suspend, flush, load_use, pc_hold;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] ex_rd, input logic ex_we, input logic ex_ld,
        input logic [4:0] mem_rd, input logic mem_we,
        input logic [4:0] wb_rd, input logic wb_we
    );
        return (r == 5'd0)                           ? 2'b00 :
               (ex_we && ex_rd == r && !ex_ld)       ? 2'b10 :
               (mem_we && mem_rd == r)               ? 2'b01 :
               (wb_we && wb_rd == r)                 ? 2'b11 : 2'b00;
    endfunction

    // A request still pending in the cycle after reset belongs to the abandoned access.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_q       <= 32'd0;
            post_rst_q    <= 1'b1;
        end else begin
            post_rst_q <= 1'b0;
            if (pc_hold && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            case (state_q)
                RUN: if (bus.mem_req && !bus.mem_ack && !post_rst_q) begin
                    state_q    <= MEM_WAIT;
                    wait_cnt_q <= 8'd0;
                end
                MEM_WAIT: if (bus.mem_ack) begin
                    state_q <= RUN;
                end else if (wait_cnt_q == LAST) begin
                    state_q       <= RUN;
                    mem_timeout_q <= 1'b1;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_comb begin
        hazard = bus.ex_is_load && bus.ex_rf_we && bus.ex_rd != 5'd0 &&
                 ((bus.id_rs1_re && bus.id_rs1 == bus.ex_rd) || (bus.id_rs2_re && bus.id_rs2 == bus.ex_rd));
        suspend  = !cpu_rst && !post_rst_q &&
                   (state_q == MEM_WAIT || (bus.mem_req && !bus.mem_ack));
        flush    = !cpu_rst && bus.ex_redirect && !suspend;
        load_use = !cpu_rst && hazard && !flush && !suspend;
        pc_hold  = suspend || load_use;
    end

    assign bus.suspend      = suspend;
    assign bus.flush        = flush;
    assign bus.load_use     = load_use;
    assign bus.pc_hold      = pc_hold;
    assign bus.if_id_hold   = pc_hold;
    assign bus.if_id_flush  = flush;
    assign bus.mem_timeout  = mem_timeout_q;
    assign bus.stall_cycles = stall_q;
    assign bus.fwd_a = cpu_rst ? 2'b00 : fwd_sel(bus.id_rs1, bus.ex_rd, bus.ex_rf_we, bus.ex_is_load,
                                                 bus.mem_rd, bus.mem_rf_we, bus.wb_rd, bus.wb_rf_we);
    assign bus.fwd_b = cpu_rst ? 2'b00 : fwd_sel(bus.id_rs2, bus.ex_rd, bus.ex_rf_we, bus.ex_is_load,
                                                 bus.mem_rd, bus.mem_rf_we, bus.wb_rd, bus.wb_rf_we);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stalls, flushes, forwarding and memory-wait timeout.
module tb_pipe_hazard_ctrl;
    logic cpu_clk = 1'b0;
    logic cpu_rst;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic clr();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_re = 0; bus.id_rs2_re = 0;
        bus.ex_rd = 0; bus.mem_rd = 0; bus.wb_rd = 0;
        bus.ex_rf_we = 0; bus.ex_is_load = 0; bus.mem_rf_we = 0; bus.wb_rf_we = 0;
        bus.ex_redirect = 0; bus.mem_req = 0; bus.mem_ack = 0;
    endtask

    task automatic set_hazard();
        bus.ex_is_load = 1; bus.ex_rf_we = 1; bus.ex_rd = 5;
        bus.id_rs1 = 5; bus.id_rs1_re = 1;
    endtask

    initial begin
        clr();
        cpu_rst = 1;
        tick();
        // Reset cycle: everything forced off even with hazards and a request present
        set_hazard(); bus.mem_rd = 5; bus.mem_rf_we = 1; bus.mem_req = 1; bus.ex_redirect = 1;
        #1;
        chk("rst_load_use", bus.load_use, 0);
        chk("rst_suspend", bus.suspend, 0);
        chk("rst_flush", bus.flush, 0);
        chk("rst_pc_hold", bus.pc_hold, 0);
        chk("rst_fwd_a", bus.fwd_a, 2'b00);
        chk("rst_stall", bus.stall_cycles, 0);
        chk("rst_timeout", bus.mem_timeout, 0);
        cpu_rst = 0;
        clr();
        tick();

        // Load x5 then add x6,x5,x7
        set_hazard(); bus.id_rs2 = 7; bus.id_rs2_re = 1;
        #1;
        chk("lu_load_use", bus.load_use, 1);
        chk("lu_pc_hold", bus.pc_hold, 1);
        chk("lu_if_id_hold", bus.if_id_hold, 1);
        tick();
        bus.ex_is_load = 0; bus.ex_rd = 6; bus.mem_rd = 5; bus.mem_rf_we = 1;
        #1;
        chk("lu2_load_use", bus.load_use, 0);
        chk("lu2_fwd_a", bus.fwd_a, 2'b01);
        chk("lu2_fwd_b", bus.fwd_b, 2'b00);
        chk("lu2_stall", bus.stall_cycles, 1);
        tick();

        // Forwarding priority
        clr();
        bus.ex_rd = 3; bus.mem_rd = 3; bus.wb_rd = 3;
        bus.ex_rf_we = 1; bus.mem_rf_we = 1; bus.wb_rf_we = 1;
        bus.id_rs1 = 3; bus.id_rs2 = 3; bus.id_rs1_re = 1; bus.id_rs2_re = 1;
        #1;
        chk("fwd_b_ex", bus.fwd_b, 2'b10);
        bus.id_rs2 = 0;
        #1;
        chk("fwd_b_x0", bus.fwd_b, 2'b00);
        bus.ex_rf_we = 0;
        #1;
        chk("fwd_a_mem", bus.fwd_a, 2'b01);
        bus.mem_rf_we = 0;
        #1;
        chk("fwd_a_wb", bus.fwd_a, 2'b11);
        bus.wb_rf_we = 0;
        #1;
        chk("fwd_a_rf", bus.fwd_a, 2'b00);
        bus.ex_rf_we = 1; bus.ex_is_load = 1; bus.mem_rf_we = 1;
        #1;
        chk("fwd_a_ld_skip", bus.fwd_a, 2'b01);
        bus.ex_rd = 0; bus.mem_rd = 0; bus.wb_rd = 0; bus.wb_rf_we = 1; bus.id_rs1 = 0;
        #1;
        chk("fwd_a_x0", bus.fwd_a, 2'b00);
        chk("lu_x0", bus.load_use, 0);
        tick();

        // Clear the stall counter for the memory-wait tests
        clr();
        cpu_rst = 1;
        tick();
        cpu_rst = 0;
        tick();

        // Ack in the last allowed wait cycle
        bus.mem_req = 1;
        #1;
        chk("mw_c0_suspend", bus.suspend, 1);
        chk("mw_c0_pc_hold", bus.pc_hold, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("mw_c%0d_suspend", i), bus.suspend, 1);
        end
        tick();
        bus.mem_ack = 1;
        #1;
        chk("mw_c4_suspend", bus.suspend, 1);
        tick();
        bus.mem_req = 0; bus.mem_ack = 0;
        #1;
        chk("mw_done_suspend", bus.suspend, 0);
        chk("mw_stall", bus.stall_cycles, 5);
        chk("mw_timeout", bus.mem_timeout, 0);

        // Redirect beats load-use in RUN
        set_hazard(); bus.ex_redirect = 1;
        #1;
        chk("rd_flush", bus.flush, 1);
        chk("rd_if_id_flush", bus.if_id_flush, 1);
        chk("rd_load_use", bus.load_use, 0);
        chk("rd_pc_hold", bus.pc_hold, 0);
        tick();

        // Redirect during a memory wait is deferred until the ack
        clr();
        bus.mem_req = 1;
        tick();
        set_hazard(); bus.ex_redirect = 1;
        #1;
        chk("rdw_flush", bus.flush, 0);
        chk("rdw_load_use", bus.load_use, 0);
        chk("rdw_pc_hold", bus.pc_hold, 1);
        tick();
        bus.mem_ack = 1;
        #1;
        chk("rdw_ack_flush", bus.flush, 0);
        tick();
        bus.mem_req = 0; bus.mem_ack = 0;
        #1;
        chk("rdw_after_flush", bus.flush, 1);
        chk("rdw_stall", bus.stall_cycles, 8);
        tick();

        // Timeout: RUN cycle plus four wait cycles, then forced back to RUN
        clr();
        bus.mem_req = 1;
        #1;
        chk("to_c0_suspend", bus.suspend, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_c%0d_suspend", i), bus.suspend, 1);
            chk($sformatf("to_c%0d_timeout", i), bus.mem_timeout, 0);
        end
        tick();
        bus.mem_req = 0;
        #1;
        chk("to_done_suspend", bus.suspend, 0);
        chk("to_timeout", bus.mem_timeout, 1);
        chk("to_stall", bus.stall_cycles, 13);
        tick();
        chk("to_sticky", bus.mem_timeout, 1);

        // Reset in the middle of a wait with a request still pending
        bus.mem_req = 1;
        for (int i = 0; i < 4; i++) tick();
        cpu_rst = 1;
        #1;
        chk("rw_rst_suspend", bus.suspend, 0);
        chk("rw_rst_pc_hold", bus.pc_hold, 0);
        tick();
        cpu_rst = 0;
        #1;
        chk("rw_post_suspend", bus.suspend, 0);
        chk("rw_post_pc_hold", bus.pc_hold, 0);
        chk("rw_post_timeout", bus.mem_timeout, 0);
        chk("rw_post_stall", bus.stall_cycles, 0);
        tick();
        bus.mem_ack = 1;
        #1;
        chk("rw_run_state", bus.suspend, 0);
        chk("rw_stall2", bus.stall_cycles, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
